div_restoring_seq: RTL
======================

# div_restoring_seq

Iterative restoring divider: accepts a dividend/divisor pair over a valid/ready handshake and returns quotient and remainder over a second handshake. It is the subtractive counterpart to the team's carry-lookahead adder, and its datapath is a per-cycle trial subtraction with borrow detection. It sits in the ALU library next to the adders, for multi-cycle division where area matters more than latency.

## Interface
- p_WIDTH, 8, operand/result width in bits; ≥ 2.
- iw_clk  in  1  clock; all state changes on rising edge.
- iw_rst  in  1  synchronous, active-high reset.
- iw_start_valid  in  1  operands present.
- ow_start_ready  out  1  divider idle, able to accept.
- iwv_dividend  in  p_WIDTH  dividend, sampled at accept edge.
- iwv_divisor  in  p_WIDTH  divisor, sampled at accept edge.
- ow_result_valid  out  1  results valid.
- iw_result_ready  in  1  consumer takes result.
- owv_quotient  out  p_WIDTH  quotient.
- owv_remainder  out  p_WIDTH  remainder.
- ow_div_by_zero  out  1  divisor was zero; qualified by ow_result_valid.

## Operation
- FSM states: IDLE, CALC, FIXUP (signed build only), DONE.
- IDLE: ow_start_ready=1. When iw_start_valid=1, operands are registered and the FSM goes to CALC. If the divisor is zero, the FSM goes straight to DONE instead.
- CALC: holds an iteration counter 0..p_WIDTH-1, a (p_WIDTH+1)-bit partial remainder R, and a quotient shift register Q. Each cycle:
  - R' = {R[p_WIDTH-1:0], next dividend MSB}.
  - D = R' − {1'b0, divisor}, computed p_WIDTH+1 bits wide.
  - If D has no borrow (D MSB=0): R←D and shift 1 into Q. Otherwise R←R' and shift 0 into Q.
- After p_WIDTH iterations the FSM goes to DONE, or to FIXUP in the signed build.
- DONE: ow_result_valid=1. owv_quotient=Q, owv_remainder=R[p_WIDTH-1:0]. All outputs hold stable while iw_result_ready=0. When iw_result_ready=1 the FSM returns to IDLE.
- Divide by zero: owv_quotient = all ones, owv_remainder = dividend, ow_div_by_zero=1.
- ow_div_by_zero is 0 for every non-zero divisor.
- No new operation is accepted before the current result handshake completes.
- iw_start_valid while busy is ignored; it is not queued.

## Timing
- Reset: state IDLE. ow_start_ready=1 from the first cycle after reset. ow_result_valid=0, owv_quotient=0, owv_remainder=0, ow_div_by_zero=0, counter=0.
- Accept at rising edge E. ow_start_ready is 0 from E onward.
- Unsigned latency: ow_result_valid first high after edge E+p_WIDTH, i.e. p_WIDTH+1 cycles from the accept cycle.
- Signed latency (macro on): one cycle more, valid after edge E+p_WIDTH+1.
- Divide by zero: valid after edge E+1 in both builds.
- Result handshake completes at edge F (valid & ready). ow_result_valid drops and ow_start_ready rises after F. The earliest next accept is edge F+1.
- Steady-state throughput: one division per p_WIDTH+2 cycles (unsigned, ready held high).
- Reset mid-operation (any state): aborts immediately; no result is produced and all outputs return to reset values.
- iw_rst has priority over every handshake on the same edge.

## Configuration
- DIV_RESTORING_SEQ_SIGNED_EN defined:
  - Operands are two's complement. The core divides magnitudes; FIXUP then negates the quotient if the operand signs differ and negates the remainder if the dividend is negative.
  - The quotient truncates toward zero and the remainder takes the dividend's sign.
  - Most-negative ÷ −1: quotient = most-negative, remainder = 0, ow_div_by_zero=0.
  - Divide by zero: quotient = all ones (−1), remainder = dividend.
- Undefined: unsigned only; no FIXUP state and no sign logic.

## Test plan
- p_WIDTH=8, unsigned, 200 ÷ 7 with iw_result_ready=1 → q=28, r=4; valid exactly 9 cycles after the accept cycle; ow_start_ready high the cycle after the handshake.
- 5 ÷ 0 → valid 1 cycle after accept; q=0xFF, r=5, ow_div_by_zero=1.
- 3 ÷ 10 with iw_result_ready held low for 3 cycles after valid → q=0, r=3; outputs constant throughout the hold; single handshake; iw_start_valid pulses during CALC are ignored.
- 255 ÷ 1 back-to-back with 0 ÷ 9 → q=255, r=0, then q=0, r=0; second accept exactly one edge after the first result handshake.
- Assert iw_rst after the 4th iteration of 100 ÷ 3 → no ow_result_valid; all outputs 0; ow_start_ready=1 the cycle after reset; next 100 ÷ 3 → q=33, r=1.
- Signed build:
  - −7 ÷ 2 → q=0xFD, r=0xFF.
  - 7 ÷ −2 → q=0xFD, r=0x01.
  - −128 ÷ −1 → q=0x80, r=0.
  - Each valid 10 cycles after accept.

Source files
------------

// File: rtl/div_restoring_seq_if.sv
// Operand and result handshakes of the restoring divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface div_restoring_seq_if #(
    parameter int p_WIDTH = 8
);
    logic               iw_start_valid;
    logic               ow_start_ready;
    logic [p_WIDTH-1:0] iwv_dividend;
    logic [p_WIDTH-1:0] iwv_divisor;
    logic               ow_result_valid;
    logic               iw_result_ready;
    logic [p_WIDTH-1:0] owv_quotient;
    logic [p_WIDTH-1:0] owv_remainder;
    logic               ow_div_by_zero;

    modport master (
        output iw_start_valid, iwv_dividend, iwv_divisor, iw_result_ready,
        input  ow_start_ready, ow_result_valid, owv_quotient, owv_remainder, ow_div_by_zero
    );

    modport slave (
        input  iw_start_valid, iwv_dividend, iwv_divisor, iw_result_ready,
        output ow_start_ready, ow_result_valid, owv_quotient, owv_remainder, ow_div_by_zero
    );
endinterface

// File: rtl/div_restoring_seq.sv
// Iterative restoring divider producing one quotient bit per cycle.
// Define DIV_RESTORING_SEQ_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module div_restoring_seq #(
    parameter int p_WIDTH = 8
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    div_restoring_seq_if.slave bus
);
    localparam int CW = $clog2(p_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [p_WIDTH-1:0] dvd_r;
    logic [p_WIDTH-1:0] dvs_r;
    logic [p_WIDTH-1:0] dq_r;
    logic [p_WIDTH-1:0] rem_r;
    logic [CW-1:0]      cnt_r;
    logic               ready_r;
    logic               valid_r;
    logic               dbz_r;
    logic [p_WIDTH-1:0] q_out_r;
    logic [p_WIDTH-1:0] r_out_r;

    logic [p_WIDTH:0]   shifted_s;
    logic [p_WIDTH:0]   diff_s;
    logic [p_WIDTH-1:0] rem_nxt_s;
    logic [p_WIDTH-1:0] dq_nxt_s;
    logic [p_WIDTH-1:0] dvd_mag_s;
    logic [p_WIDTH-1:0] dvs_mag_s;
    logic [p_WIDTH-1:0] res_q_s;
    logic [p_WIDTH-1:0] res_r_s;
    logic               res_dbz_s;
    logic               accept_s;
    logic               iter_s;
    logic               load_s;
    logic               release_s;
    logic               last_iter_s;

`ifdef DIV_RESTORING_SEQ_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;

    function automatic logic [p_WIDTH-1:0] magnitude(input logic [p_WIDTH-1:0] v);
        return v[p_WIDTH-1] ? -v : v;
    endfunction

    // Operand conditioning: the core only ever divides magnitudes.
    always_comb begin
        dvd_mag_s = magnitude(bus.iwv_dividend);
        dvs_mag_s = magnitude(bus.iwv_divisor);
    end
`else
    // Operand conditioning: unsigned operands enter the core unchanged.
    always_comb begin
        dvd_mag_s = bus.iwv_dividend;
        dvs_mag_s = bus.iwv_divisor;
    end
`endif

    // One restoring step. dq_r shifts dividend bits out of its MSB while
    // quotient bits enter at its LSB, so after p_WIDTH steps it holds Q.
    // The kept remainder is always below the divisor, so p_WIDTH bits suffice;
    // only the trial value R' needs the extra bit.
    always_comb begin
        shifted_s = {rem_r, dq_r[p_WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        if (diff_s[p_WIDTH] == 1'b0) begin
            rem_nxt_s = diff_s[p_WIDTH-1:0];
            dq_nxt_s  = {dq_r[p_WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = shifted_s[p_WIDTH-1:0];
            dq_nxt_s  = {dq_r[p_WIDTH-2:0], 1'b0};
        end
    end

    assign last_iter_s = (cnt_r == CW'(p_WIDTH - 1));

    // FSM state register.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        iter_s       = 1'b0;
        load_s       = 1'b0;
        release_s    = 1'b0;
        res_q_s      = dq_nxt_s;
        res_r_s      = rem_nxt_s;
        res_dbz_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.iw_start_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = (bus.iwv_divisor == {p_WIDTH{1'b0}}) ? S_DONE : S_CALC;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CALC: begin
                iter_s = 1'b1;
                if (last_iter_s) begin
`ifdef DIV_RESTORING_SEQ_SIGNED_EN
                    next_state_s = S_FIXUP;
`else
                    load_s       = 1'b1;
                    next_state_s = S_DONE;
`endif
                end else begin
                    next_state_s = S_CALC;
                end
            end
`ifdef DIV_RESTORING_SEQ_SIGNED_EN
            S_FIXUP: begin
                load_s       = 1'b1;
                res_q_s      = neg_q_r ? -dq_r : dq_r;
                res_r_s      = neg_r_r ? -rem_r : rem_r;
                next_state_s = S_DONE;
            end
`endif
            S_DONE: begin
                // Entered with valid low only on a zero divisor.
                if (!valid_r) begin
                    load_s    = 1'b1;
                    res_q_s   = {p_WIDTH{1'b1}};
                    res_r_s   = dvd_r;
                    res_dbz_s = 1'b1;
                end else if (bus.iw_result_ready) begin
                    release_s    = 1'b1;
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration registers and registered outputs.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            dvd_r   <= {p_WIDTH{1'b0}};
            dvs_r   <= {p_WIDTH{1'b0}};
            dq_r    <= {p_WIDTH{1'b0}};
            rem_r   <= {p_WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            dbz_r   <= 1'b0;
            q_out_r <= {p_WIDTH{1'b0}};
            r_out_r <= {p_WIDTH{1'b0}};
`ifdef DIV_RESTORING_SEQ_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            if (accept_s) begin
                dvd_r   <= bus.iwv_dividend;
                dvs_r   <= dvs_mag_s;
                dq_r    <= dvd_mag_s;
                rem_r   <= {p_WIDTH{1'b0}};
                cnt_r   <= {CW{1'b0}};
                ready_r <= 1'b0;
`ifdef DIV_RESTORING_SEQ_SIGNED_EN
                neg_q_r <= bus.iwv_dividend[p_WIDTH-1] ^ bus.iwv_divisor[p_WIDTH-1];
                neg_r_r <= bus.iwv_dividend[p_WIDTH-1];
`endif
            end else if (iter_s) begin
                dq_r  <= dq_nxt_s;
                rem_r <= rem_nxt_s;
                cnt_r <= cnt_r + CW'(1);
            end
            if (load_s) begin
                q_out_r <= res_q_s;
                r_out_r <= res_r_s;
                dbz_r   <= res_dbz_s;
                valid_r <= 1'b1;
            end else if (release_s) begin
                valid_r <= 1'b0;
                ready_r <= 1'b1;
            end
        end
    end

    assign bus.ow_start_ready  = ready_r;
    assign bus.ow_result_valid = valid_r;
    assign bus.owv_quotient    = q_out_r;
    assign bus.owv_remainder   = r_out_r;
    assign bus.ow_div_by_zero  = dbz_r;
endmodule
